// File: rtl/threshold_comparator_if.sv
// Sample bus for the StrADC threshold comparator: run control,
// lane samples, trigger flags and the pretrigger-delayed sample word.
interface threshold_comparator_if #(
  parameter int N      = 4,
  parameter int n_bits = 10
);
  logic                enable;
  logic [N*n_bits-1:0] signals;
  logic [n_bits-1:0]   threshold;
  logic [1:0]          pretrigger_select;
  logic [N-1:0]        triggered;
  logic [N*n_bits-1:0] delayed_signals;

  modport master (
    output enable, signals, threshold, pretrigger_select,
    input  triggered, delayed_signals
  );

  modport slave (
    input  enable, signals, threshold, pretrigger_select,
    output triggered, delayed_signals
  );
endinterface

// File: rtl/threshold_comparator.sv
// Per-lane threshold trigger plus a whole-frame pretrigger delay line
// for the StrADC front end.
module threshold_comparator #(
  parameter int N        = 4,
  parameter int n_bits   = 10,
  parameter int channels = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  threshold_comparator_if.slave bus
);
  localparam int DEPTH = 16 * channels;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int W     = N * n_bits;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [FW-1:0] r_fill;
  logic [4:0]    r_p;
  logic [N-1:0]  r_trig;
  logic [W-1:0]  r_dly;

  logic [4:0]    w_p_dec;
  logic [FW-1:0] w_delay;
  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] w_wr_next;
  logic [N-1:0]  w_gt;
  logic [W-1:0]  w_rd_word;

  always_comb begin
    w_p_dec = 5'd0;
    unique case (bus.pretrigger_select)
      2'b00: w_p_dec = 5'd0;
      2'b01: w_p_dec = 5'd4;
      2'b10: w_p_dec = 5'd8;
      2'b11: w_p_dec = 5'd16;
    endcase
  end

  assign w_delay   = FW'(r_p) * FW'(channels);
  assign w_rd_addr = r_wr_ptr - w_delay[AW-1:0];
  assign w_wr_next = (r_wr_ptr == AW'(DEPTH - 1))
                   ? '0 : r_wr_ptr + 1'b1;

  // Zero delay reads the word being written this cycle, so bypass the RAM
  assign w_rd_word = (w_delay == '0) ? bus.signals
                                     : r_mem[w_rd_addr];

  always_comb begin
    w_gt = '0;
    for (int k = 0; k < N; k++)
      w_gt[k] = bus.signals[k*n_bits +: n_bits] > bus.threshold;
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.enable)
      r_mem[r_wr_ptr] <= bus.signals;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p      <= '0;
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_trig   <= '0;
      r_dly    <= '0;
    end else if (!bus.enable) begin
      r_p    <= w_p_dec;
      r_fill <= '0;
      r_trig <= '0;
      r_dly  <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      if (r_fill < w_delay)
        r_fill <= r_fill + 1'b1;
      r_trig <= w_gt;
      r_dly  <= (r_fill < w_delay) ? '0 : w_rd_word;
    end
  end

  assign bus.triggered       = r_trig;
  assign bus.delayed_signals = r_dly;
endmodule

// File: tb/tb_threshold_comparator.sv
// Randomized bench for threshold_comparator against a queue-based
// model of the trigger and pretrigger delay behaviour.
module tb_threshold_comparator;
  localparam int N  = 4;
  localparam int NB = 10;
  localparam int CH = 32;
  localparam int W  = N * NB;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  threshold_comparator_if #(.N(N), .n_bits(NB)) bus ();

  threshold_comparator #(.N(N), .n_bits(NB), .channels(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] hist [$];
  int           m_p = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dec_sel(logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  task automatic step(bit r, bit en, logic [1:0] sel,
                      logic [NB-1:0] thr, logic [W-1:0] sig);
    logic [N-1:0] e_t;
    logic [W-1:0] e_d;
    int d;
    int last;
    rst                   = r;
    bus.enable            = en;
    bus.pretrigger_select = sel;
    bus.threshold         = thr;
    bus.signals           = sig;
    e_t = '0;
    e_d = '0;
    if (r) begin
      hist.delete();
      m_p = 0;
    end else if (!en) begin
      hist.delete();
      m_p = dec_sel(sel);
    end else begin
      hist.push_back(sig);
      d    = m_p * CH;
      last = hist.size() - 1;
      if (last >= d) e_d = hist[last - d];
      for (int k = 0; k < N; k++)
        e_t[k] = sig[k*NB +: NB] > thr;
    end
    @(posedge clk);
    @(negedge clk);
    chk("trig", 64'(bus.triggered), 64'(e_t));
    chk("dly", 64'(bus.delayed_signals), 64'(e_d));
  endtask

  function automatic logic [W-1:0] rnd_sig();
    logic [W-1:0] s;
    for (int k = 0; k < N; k++)
      s[k*NB +: NB] = NB'($urandom_range(1023));
    return s;
  endfunction

  initial begin
    logic [W-1:0] s;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.signals = '0;
    bus.threshold = '0;
    bus.pretrigger_select = 2'b00;
    @(negedge clk);

    // Reset with nonzero inputs
    for (int i = 0; i < 2; i++)
      step(1, 1, 2'b11, 10'd0, rnd_sig());

    // Trigger and zero delay: lane0 = ch, lane1 = frame
    step(0, 0, 2'b00, 10'd10, '0);
    for (int i = 0; i < 32; i++)
      for (int c = 0; c < CH; c++) begin
        s = '0;
        s[0  +: NB] = NB'(c);
        s[NB +: NB] = NB'(i);
        step(0, 1, 2'b00, 10'd10, s);
      end

    // Pretrigger 8 frames with a ramp on lane0
    for (int i = 0; i < 3; i++)
      step(0, 0, 2'b10, 10'd500, rnd_sig());
    for (int i = 0; i < 600; i++) begin
      s = rnd_sig();
      s[0 +: NB] = NB'(i);
      step(0, 1, 2'b10, 10'd500, s);
    end

    // Select change while running must not alter the delay
    for (int i = 0; i < 300; i++)
      step(0, 1, 2'b11, 10'd500, rnd_sig());
    for (int i = 0; i < 2; i++)
      step(0, 0, 2'b11, 10'd500, rnd_sig());
    // Enable rises with a new select: last idle value wins
    step(0, 1, 2'b01, 10'd500, rnd_sig());
    for (int i = 0; i < 1100; i++)
      step(0, 1, 2'($urandom_range(3)), 10'd500, rnd_sig());

    // Idle with maximal lane0 and zero threshold
    s = rnd_sig();
    s[0 +: NB] = 10'd1023;
    step(0, 0, 2'b00, 10'd0, s);
    step(0, 0, 2'b00, 10'd0, s);

    // Mid-run reset, then random traffic with occasional idles
    for (int i = 0; i < 40; i++)
      step(0, 1, 2'b00, 10'd300, rnd_sig());
    step(1, 1, 2'b00, 10'd300, rnd_sig());
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(499) == 0),
           ($urandom_range(199) != 0),
           2'($urandom_range(3)),
           NB'($urandom_range(1023)),
           rnd_sig());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
